uart_pkt_sched: RTL

Round-robin packet scheduler that shares one `uart_tx` byte serializer between the correlator's CHANNELS result producers. It grants one requester at a time and latches that requester's WORD_BYTES-byte word. It then drives the serializer's `din`/`tx_start`/`tx_done` handshake to emit a framed packet: sync, channel index, data bytes LSB first, then XOR checksum. It sits between the correlator's channel counters and the `uart_tx` instance.

---
 rtl/uart_pkt_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_pkt_sched.sv
// Round-robin packet scheduler in front of a shared uart_tx byte serializer.
// Frames each granted word as SYNC, channel index, data bytes (LSB first), XOR checksum.
module uart_pkt_sched #(
  parameter int         CHANNELS   = 12,
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         TIMEOUT    = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CHANNELS-1:0]              req,
  input  logic [CHANNELS*WORD_BYTES*8-1:0] data,
  output logic [CHANNELS-1:0]              ack,
  output logic                             busy,
  output logic                             pkt_done,
  output logic                             err,
  output logic [7:0]                       uart_din,
  output logic                             uart_tx_start,
  input  logic                             uart_tx_done
);
  localparam int WW   = WORD_BYTES * 8;
  localparam int BW   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int LAST = WORD_BYTES + 2;  // byte index of the checksum

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t                           r_state, w_next;
  logic [7:0]                       r_last;   // last granted channel, also the index byte
  logic [7:0]                       r_chk;
  logic [4:0]                       r_bidx;   // index of the byte currently on uart_din
  logic [TW-1:0]                    r_timer;
  logic [WORD_BYTES-1:0][7:0]       r_word;

  logic                             w_hi_found, w_lo_found, w_found;
  logic [7:0]                       w_hi_win, w_lo_win, w_win;
  logic [CHANNELS-1:0]              w_ack;
  logic [WORD_BYTES-1:0][7:0]       w_wsel;
  logic [4:0]                       w_bm1;
  logic [7:0]                       w_nbyte;
  logic                             w_more, w_tmo;

  // Round-robin search: first requester above last grant, else first at/below it
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_win   = 8'd0;
    w_lo_found = 1'b0;
    w_lo_win   = 8'd0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(r_last))) begin
        w_hi_found = 1'b1;
        w_hi_win   = 8'(i);
      end
      if (req[i] && (i <= int'(r_last))) begin
        w_lo_found = 1'b1;
        w_lo_win   = 8'(i);
      end
    end
    w_found = w_hi_found | w_lo_found;
    w_win   = w_hi_found ? w_hi_win : w_lo_win;
  end

  // Winner's one-hot ack and its word
  always_comb begin
    w_ack  = '0;
    w_wsel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_win == 8'(i)) begin
        w_ack[i] = 1'b1;
        w_wsel   = data[i*WW +: WW];
      end
    end
  end

  // Byte that follows the current one: index, data bytes, then checksum
  always_comb begin
    w_bm1   = r_bidx - 5'd1;
    w_nbyte = r_chk;
    if (r_bidx == 5'd0)
      w_nbyte = r_last;
    else if (int'(r_bidx) <= WORD_BYTES)
      w_nbyte = r_word[w_bm1[BW-1:0]];
    w_more = (r_bidx != 5'(LAST));
    w_tmo  = (int'(r_timer) + 1 == TIMEOUT);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state; a done with bytes remaining re-issues start on the same edge,
  // so the SEND step is folded in and WAIT is re-entered without a bubble
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next = SEND;
      SEND:    w_next = WAIT;
      WAIT: begin
        if (uart_tx_done) w_next = w_more ? WAIT : IDLE;
        else if (w_tmo)   w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Registered outputs and packet datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack           <= '0;
      busy          <= 1'b0;
      pkt_done      <= 1'b0;
      err           <= 1'b0;
      uart_din      <= 8'h00;
      uart_tx_start <= 1'b0;
      r_last        <= 8'(CHANNELS - 1);
      r_chk         <= 8'h00;
      r_bidx        <= 5'd0;
      r_timer       <= '0;
      r_word        <= '0;
    end else begin
      ack           <= '0;
      pkt_done      <= 1'b0;
      err           <= 1'b0;
      uart_tx_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            ack      <= w_ack;
            r_word   <= w_wsel;
            r_last   <= w_win;
            busy     <= 1'b1;
            uart_din <= SYNC_BYTE;
            r_chk    <= 8'h00;
            r_bidx   <= 5'd0;
          end
        end
        SEND: begin
          uart_tx_start <= 1'b1;
          r_timer       <= '0;
        end
        WAIT: begin
          if (uart_tx_done) begin
            if (w_more) begin
              uart_din      <= w_nbyte;
              uart_tx_start <= 1'b1;
              r_timer       <= '0;
              r_bidx        <= r_bidx + 5'd1;
              if (int'(r_bidx) <= WORD_BYTES) r_chk <= r_chk ^ w_nbyte;
            end else begin
              pkt_done <= 1'b1;
              busy     <= 1'b0;
            end
          end else if (w_tmo) begin
            err      <= 1'b1;
            busy     <= 1'b0;
            uart_din <= 8'h00;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
